// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared opcode, state, branch-condition and write-back encodings for the CPU control sequencer.
package cpu_ctrl_fsm_pkg;

   localparam logic [3:0] OP_ADD    = 4'h0;
   localparam logic [3:0] OP_SUB    = 4'h1;
   localparam logic [3:0] OP_XOR    = 4'h2;
   localparam logic [3:0] OP_RED    = 4'h3;
   localparam logic [3:0] OP_SLL    = 4'h4;
   localparam logic [3:0] OP_SRA    = 4'h5;
   localparam logic [3:0] OP_ROR    = 4'h6;
   localparam logic [3:0] OP_PADDSB = 4'h7;
   localparam logic [3:0] OP_LW     = 4'h8;
   localparam logic [3:0] OP_SW     = 4'h9;
   localparam logic [3:0] OP_LLB    = 4'hA;
   localparam logic [3:0] OP_LHB    = 4'hB;
   localparam logic [3:0] OP_B      = 4'hC;
   localparam logic [3:0] OP_BR     = 4'hD;
   localparam logic [3:0] OP_PCS    = 4'hE;
   localparam logic [3:0] OP_HLT    = 4'hF;

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_DECODE  = 3'd1,
      ST_EXECUTE = 3'd2,
      ST_MEM     = 3'd3,
      ST_WB      = 3'd4,
      ST_HALT    = 3'd5
   } state_t;

   localparam logic [2:0] CC_NE = 3'b000;
   localparam logic [2:0] CC_EQ = 3'b001;
   localparam logic [2:0] CC_GT = 3'b010;
   localparam logic [2:0] CC_LT = 3'b011;
   localparam logic [2:0] CC_GE = 3'b100;
   localparam logic [2:0] CC_LE = 3'b101;
   localparam logic [2:0] CC_OV = 3'b110;
   localparam logic [2:0] CC_AL = 3'b111;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC  = 2'b10;

   // Flag-register write masks in {Z,V,N} order
   localparam logic [2:0] FLAG_ALL  = 3'b111;
   localparam logic [2:0] FLAG_Z    = 3'b100;
   localparam logic [2:0] FLAG_NONE = 3'b000;

   function automatic logic uses_imm(input logic [3:0] op);
      case (op)
         OP_SLL, OP_SRA, OP_ROR, OP_LW, OP_SW, OP_LLB, OP_LHB: uses_imm = 1'b1;
         default: uses_imm = 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] flag_mask(input logic [3:0] op);
      case (op)
         OP_ADD, OP_SUB:                 flag_mask = FLAG_ALL;
         OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_mask = FLAG_Z;
         OP_RED, OP_PADDSB:              flag_mask = FLAG_NONE;
         default:                        flag_mask = FLAG_NONE;
      endcase
   endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_branch_cond.sv
// Branch condition evaluator: compares a 3-bit condition code against the latched {Z,V,N} flags.
module branch_cond
   import cpu_ctrl_fsm_pkg::*;
(
   input  logic [2:0] i_ccc,
   input  logic [2:0] i_flags,
   output logic       o_taken
);

   logic w_z;
   logic w_v;
   logic w_n;

   assign {w_z, w_v, w_n} = i_flags;

   // Condition decode
   always_comb begin
      o_taken = 1'b0;
      case (i_ccc)
         CC_NE:   o_taken = !w_z;
         CC_EQ:   o_taken = w_z;
         CC_GT:   o_taken = !w_z && !w_n;
         CC_LT:   o_taken = w_n;
         CC_GE:   o_taken = w_z || !w_n;
         CC_LE:   o_taken = w_z || w_n;
         CC_OV:   o_taken = w_v;
         CC_AL:   o_taken = 1'b1;
         default: o_taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXECUTE/MEM/WB with flag register,
// branch resolution and memory-handshake timeout into a sticky error halt.
module cpu_ctrl_fsm
   import cpu_ctrl_fsm_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int MEM_TIMEOUT = 16
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] instr,
   input  logic              imem_ready,
   input  logic              dmem_ready,
   input  logic              Z,
   input  logic              V,
   input  logic              N,
   output logic [3:0]        ALU_operation,
   output logic              ALUSrc,
   output logic              PCSrc,
   output logic              pc_write,
   output logic              ir_write,
   output logic              reg_write,
   output logic              mem_read,
   output logic              mem_write,
   output logic [1:0]        wb_sel,
   output logic [2:0]        flags,
   output logic              halt,
   output logic              err
);

   localparam int              CNT_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_t           r_state;
   state_t           w_next_state;
   logic [3:0]       r_op;
   logic [2:0]       r_ccc;
   logic [2:0]       r_flags;
   logic [CNT_W-1:0] r_wait;
   logic             r_err;

   logic [3:0]       w_op;
   logic [2:0]       w_ccc;
   logic [2:0]       w_mask;
   logic             w_taken;
   logic             w_waiting;
   logic             w_timeout;
   logic             w_unused_instr;

   assign w_op           = instr[DATA_W-1 -: 4];
   assign w_ccc          = instr[DATA_W-5 -: 3];
   assign w_unused_instr = ^instr[DATA_W-8:0];
   assign w_mask         = flag_mask(r_op);
   assign flags          = r_flags;
   assign err            = r_err;

   branch_cond u_branch_cond (
      .i_ccc   (r_ccc),
      .i_flags (r_flags),
      .o_taken (w_taken)
   );

   // State, instruction fields, flag register, wait counter and sticky error
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_FETCH;
         r_op    <= 4'h0;
         r_ccc   <= 3'b000;
         r_flags <= 3'b000;
         r_wait  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (ir_write) begin
            r_op  <= w_op;
            r_ccc <= w_ccc;
         end
         // Flags come from the ALU in the same cycle as EXECUTE; masked per opcode
         if (r_state == ST_EXECUTE) begin
            r_flags <= (r_flags & ~w_mask) | ({Z, V, N} & w_mask);
         end
         if (w_next_state != r_state) begin
            r_wait <= '0;
         end else if (w_waiting) begin
            r_wait <= r_wait + 1'b1;
         end
         if (w_timeout) begin
            r_err <= 1'b1;
         end
      end
   end

   // Next-state and Moore output decode
   always_comb begin
      w_next_state  = ST_FETCH;
      w_waiting     = 1'b0;
      w_timeout     = 1'b0;
      ALU_operation = 4'h0;
      ALUSrc        = 1'b0;
      PCSrc         = 1'b0;
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      wb_sel        = WB_ALU;
      halt          = 1'b0;
      case (r_state)
         ST_FETCH: begin
            if (imem_ready) begin
               ir_write     = 1'b1;
               pc_write     = 1'b1;
               w_next_state = ST_DECODE;
            end else begin
               w_waiting = 1'b1;
               if (r_wait == TO_LAST) begin
                  w_timeout    = 1'b1;
                  w_next_state = ST_HALT;
               end else begin
                  w_next_state = ST_FETCH;
               end
            end
         end
         ST_DECODE: begin
            w_next_state = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            ALU_operation = r_op;
            ALUSrc        = uses_imm(r_op);
            case (r_op)
               OP_LW, OP_SW: w_next_state = ST_MEM;
               OP_B, OP_BR: begin
                  w_next_state = ST_FETCH;
                  if (w_taken) begin
                     PCSrc    = 1'b1;
                     pc_write = 1'b1;
                  end else begin
                     PCSrc    = 1'b0;
                     pc_write = 1'b0;
                  end
               end
               OP_HLT:  w_next_state = ST_HALT;
               default: w_next_state = ST_WB;
            endcase
         end
         ST_MEM: begin
            mem_read  = (r_op == OP_LW);
            mem_write = (r_op != OP_LW);
            if (dmem_ready) begin
               w_next_state = (r_op == OP_LW) ? ST_WB : ST_FETCH;
            end else begin
               // A ready arriving on the last allowed cycle is taken above, not here
               w_waiting = 1'b1;
               if (r_wait == TO_LAST) begin
                  w_timeout    = 1'b1;
                  w_next_state = ST_HALT;
               end else begin
                  w_next_state = ST_MEM;
               end
            end
         end
         ST_WB: begin
            reg_write    = 1'b1;
            w_next_state = ST_FETCH;
            case (r_op)
               OP_LW:   wb_sel = WB_MEM;
               OP_PCS:  wb_sel = WB_PC;
               default: wb_sel = WB_ALU;
            endcase
         end
         ST_HALT: begin
            halt         = 1'b1;
            w_next_state = ST_HALT;
         end
         default: begin
            w_next_state = ST_FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench: table of single-instruction runs checked through a scoreboard queue,
// plus hand-written sequences for halt persistence, memory timeout and reset mid-instruction.
module tb_cpu_ctrl_fsm;

   logic        clk;
   logic        rst_n;
   logic [15:0] instr;
   logic        imem_ready;
   logic        dmem_ready;
   logic        Z, V, N;
   logic [3:0]  ALU_operation;
   logic        ALUSrc, PCSrc, pc_write, ir_write, reg_write, mem_read, mem_write;
   logic [1:0]  wb_sel;
   logic [2:0]  flags;
   logic        halt, err;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [15:0] instr;
      logic [2:0]  zvn;     // ALU flags driven during EXECUTE
      int          dly;     // dmem_ready low cycles in MEM
      int          lat;     // cycles until next FETCH (or until HALT)
      logic        halt;
      int          rw;
      logic [1:0]  wbs;
      int          br;      // PCSrc&pc_write cycles
      int          mr;
      int          mw;
      logic [3:0]  aluop;
      logic        alusrc;
      logic [2:0]  flags;   // flag register after the instruction
   } vec_t;

   vec_t tbl[19];
   vec_t sb_q[$];

   cpu_ctrl_fsm #(.DATA_W(16), .MEM_TIMEOUT(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .instr         (instr),
      .imem_ready    (imem_ready),
      .dmem_ready    (dmem_ready),
      .Z             (Z),
      .V             (V),
      .N             (N),
      .ALU_operation (ALU_operation),
      .ALUSrc        (ALUSrc),
      .PCSrc         (PCSrc),
      .pc_write      (pc_write),
      .ir_write      (ir_write),
      .reg_write     (reg_write),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .wb_sel        (wb_sel),
      .flags         (flags),
      .halt          (halt),
      .err           (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Called at a negedge; returns at a negedge after one reset edge
   task automatic do_reset();
      rst_n      = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      {Z, V, N}  = 3'b000;
      @(negedge clk);
      check("reset_state",
            int'({ALU_operation, ALUSrc, PCSrc, pc_write, ir_write, reg_write,
                  mem_read, mem_write, wb_sel, flags, halt, err}), 0);
      rst_n = 1'b1;
   endtask

   // Entered at a negedge with the DUT in FETCH; ends at the negedge of the next FETCH or HALT
   task automatic run_instr(input vec_t v, input string nm);
      int   k, m, rw, br, mr, mw;
      logic [1:0] wbs;
      logic [3:0] aop;
      logic asrc;
      logic hseen;
      logic done;
      vec_t e;
      k = 1; m = 0; rw = 0; br = 0; mr = 0; mw = 0;
      wbs = 2'b00; aop = 4'h0; asrc = 1'b0; hseen = 1'b0; done = 1'b0;
      sb_q.push_back(v);
      instr      = v.instr;
      imem_ready = 1'b1;
      dmem_ready = 1'b0;
      {Z, V, N}  = v.zvn;
      while (!done && k < 100) begin
         @(negedge clk);
         k++;
         if (halt) begin
            hseen = 1'b1;
            done  = 1'b1;
            dmem_ready = 1'b0;
         end else if (ir_write) begin
            done = 1'b1;
            dmem_ready = 1'b0;
         end else begin
            if (k == 3) begin
               aop  = ALU_operation;
               asrc = ALUSrc;
            end
            if (reg_write) begin
               rw++;
               wbs = wb_sel;
            end
            if (pc_write && PCSrc) br++;
            if (mem_read || mem_write) begin
               m++;
               if (mem_read) mr++;
               if (mem_write) mw++;
               dmem_ready = (m > v.dly);
            end else begin
               dmem_ready = 1'b0;
            end
         end
      end
      if (sb_q.size() == 0) begin
         check({nm, "_sb_empty"}, 1, 0);
      end else begin
         e = sb_q.pop_front();
         check({nm, "_lat"},    k - 1,      e.lat);
         check({nm, "_halt"},   int'(hseen), int'(e.halt));
         check({nm, "_rw"},     rw,         e.rw);
         check({nm, "_wbsel"},  int'(wbs),  int'(e.wbs));
         check({nm, "_br"},     br,         e.br);
         check({nm, "_mrd"},    mr,         e.mr);
         check({nm, "_mwr"},    mw,         e.mw);
         check({nm, "_aluop"},  int'(aop),  int'(e.aluop));
         check({nm, "_alusrc"}, int'(asrc), int'(e.alusrc));
         check({nm, "_flags"},  int'(flags), int'(e.flags));
      end
   endtask

   initial begin
      vec_t tv;
      int   rw_seen;
      //        instr     zvn    dly lat h  rw wbs   br mr mw aluop alusrc flags
      tbl[0]  = '{16'h0123, 3'b011, 0, 4, 1'b0, 1, 2'b00, 0, 0, 0, 4'h0, 1'b0, 3'b011}; // ADD
      tbl[1]  = '{16'h2456, 3'b100, 0, 4, 1'b0, 1, 2'b00, 0, 0, 0, 4'h2, 1'b0, 3'b111}; // XOR: Z only
      tbl[2]  = '{16'hA0FF, 3'b000, 0, 4, 1'b0, 1, 2'b00, 0, 0, 0, 4'hA, 1'b1, 3'b111}; // LLB: keep
      tbl[3]  = '{16'hC200, 3'b000, 0, 3, 1'b0, 0, 2'b00, 1, 0, 0, 4'hC, 1'b0, 3'b111}; // B EQ taken
      tbl[4]  = '{16'hC000, 3'b000, 0, 3, 1'b0, 0, 2'b00, 0, 0, 0, 4'hC, 1'b0, 3'b111}; // B NE not
      tbl[5]  = '{16'h1000, 3'b100, 0, 4, 1'b0, 1, 2'b00, 0, 0, 0, 4'h1, 1'b0, 3'b100}; // SUB
      tbl[6]  = '{16'hD400, 3'b000, 0, 3, 1'b0, 0, 2'b00, 0, 0, 0, 4'hD, 1'b0, 3'b100}; // BR GT not
      tbl[7]  = '{16'hD800, 3'b011, 0, 3, 1'b0, 0, 2'b00, 1, 0, 0, 4'hD, 1'b0, 3'b100}; // BR GE taken
      tbl[8]  = '{16'h0000, 3'b001, 0, 4, 1'b0, 1, 2'b00, 0, 0, 0, 4'h0, 1'b0, 3'b001}; // ADD
      tbl[9]  = '{16'hC600, 3'b000, 0, 3, 1'b0, 0, 2'b00, 1, 0, 0, 4'hC, 1'b0, 3'b001}; // B LT taken
      tbl[10] = '{16'hCC00, 3'b010, 0, 3, 1'b0, 0, 2'b00, 0, 0, 0, 4'hC, 1'b0, 3'b001}; // B OV not
      tbl[11] = '{16'hCE00, 3'b000, 0, 3, 1'b0, 0, 2'b00, 1, 0, 0, 4'hC, 1'b0, 3'b001}; // B always
      tbl[12] = '{16'h8123, 3'b000, 3, 8, 1'b0, 1, 2'b01, 0, 4, 0, 4'h8, 1'b1, 3'b001}; // LW wait 3
      tbl[13] = '{16'h9000, 3'b000, 0, 4, 1'b0, 0, 2'b00, 0, 0, 1, 4'h9, 1'b1, 3'b001}; // SW
      tbl[14] = '{16'hE000, 3'b000, 0, 4, 1'b0, 1, 2'b10, 0, 0, 0, 4'hE, 1'b0, 3'b001}; // PCS
      tbl[15] = '{16'h5000, 3'b110, 0, 4, 1'b0, 1, 2'b00, 0, 0, 0, 4'h5, 1'b1, 3'b101}; // SRA: Z only
      tbl[16] = '{16'h7000, 3'b111, 0, 4, 1'b0, 1, 2'b00, 0, 0, 0, 4'h7, 1'b0, 3'b101}; // PADDSB: keep
      tbl[17] = '{16'hCA00, 3'b000, 0, 3, 1'b0, 0, 2'b00, 1, 0, 0, 4'hC, 1'b0, 3'b101}; // B LE taken
      tbl[18] = '{16'hF000, 3'b111, 0, 3, 1'b1, 0, 2'b00, 0, 0, 0, 4'hF, 1'b0, 3'b101}; // HLT

      rst_n = 1'b0; instr = 16'h0000; imem_ready = 1'b0; dmem_ready = 1'b0; {Z, V, N} = 3'b000;
      do_reset();

      for (int i = 0; i < 19; i++) begin
         run_instr(tbl[i], $sformatf("v%0d", i));
      end

      // HALT is terminal: fetch requests are ignored
      instr = 16'h0000;
      imem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("halt_hold", int'({halt, ir_write, pc_write}), 3'b100);
      end
      check("halt_no_err", int'(err), 0);

      // Data memory never ready: timeout into HALT with sticky error
      do_reset();
      tv = '{16'h8000, 3'b000, 99, 19, 1'b1, 0, 2'b00, 0, 16, 0, 4'h8, 1'b1, 3'b000};
      run_instr(tv, "timeout");
      check("timeout_err", int'({err, halt}), 2'b11);
      @(negedge clk);
      check("timeout_err_sticky", int'({err, halt}), 2'b11);

      // Reset clears the error; ready on the last allowed cycle still completes normally
      do_reset();
      tv = '{16'h8000, 3'b000, 15, 20, 1'b0, 1, 2'b01, 0, 16, 0, 4'h8, 1'b1, 3'b000};
      run_instr(tv, "ready_at_limit");
      check("ready_at_limit_err", int'(err), 0);

      // Reset in the middle of a load abandons it
      instr = 16'h8000;
      imem_ready = 1'b1;
      dmem_ready = 1'b0;
      for (int i = 0; i < 10 && !mem_read; i++) @(negedge clk);
      check("midlw_in_mem", int'(mem_read), 1);
      imem_ready = 1'b0;
      rst_n      = 1'b0;
      dmem_ready = 1'b1;
      @(negedge clk);
      rst_n   = 1'b1;
      rw_seen = int'(reg_write || mem_read);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (reg_write || mem_read) rw_seen++;
      end
      check("midlw_no_write", rw_seen, 0);
      imem_ready = 1'b1;
      #1;
      check("midlw_back_fetch", int'(ir_write), 1);
      @(negedge clk);
      imem_ready = 1'b0;
      dmem_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
